// File: rtl/usb_nrzi_tx.sv
// usb_nrzi_tx
// Full-speed USB transmit line stage. Takes the packet encoder's serial,
// LSB-first bit stream over a valid/ready handshake, prepends SYNC, inserts
// a stuff bit after every six consecutive ones, NRZI-encodes the result and
// appends EOP (SE0, SE0, J). One clk cycle is one bit time.
//
// Ports
//   clk       in   bit clock, rising edge active
//   rst_L     in   asynchronous active-low reset
//   in_valid  in   upstream presents a bit on in_bit
//   in_bit    in   next unencoded packet bit (LSB-first)
//   in_last   in   in_bit is the final bit of the packet
//   in_ready  out  combinational, high only in DATA
//   dp, dm    out  registered D+/D- line values
//   out_en    out  registered, high while the host drives the bus
//   busy      out  registered, high from first SYNC symbol through EOP J
//   underrun  out  registered one-cycle pulse on a starvation abort
//
// Each state decides the symbol loaded on the edge that leaves it, so the
// symbol shows on the line during the cycle after that edge.
//
// state | meaning
// IDLE  | bus idle (J, out_en=0); in_valid loads the first SYNC symbol
// SYNC  | emitting SYNC symbols 2..8
// DATA  | consume one bit per cycle; starvation aborts to EOP2
// STUFF | emit a stuffed 0 (toggle) after six consecutive ones
// EOP1  | load first SE0
// EOP2  | load second SE0
// EOPJ  | load the closing J, then back to IDLE

module usb_nrzi_tx (
  input  logic clk,
  input  logic rst_L,
  input  logic in_valid,
  input  logic in_bit,
  input  logic in_last,
  output logic in_ready,
  output logic dp,
  output logic dm,
  output logic out_en,
  output logic busy,
  output logic underrun
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SYNC  = 3'd1,
    DATA  = 3'd2,
    STUFF = 3'd3,
    EOP1  = 3'd4,
    EOP2  = 3'd5,
    EOPJ  = 3'd6
  } state_t;

  state_t     state, state_nxt;
  logic [2:0] sync_cnt, sync_cnt_nxt;
  logic [2:0] ones_cnt, ones_cnt_nxt;
  // NRZI reference: 0 = J, 1 = K (last J/K driven)
  logic       ref_k, ref_k_nxt;
  logic       last_flag, last_flag_nxt;
  logic       dp_nxt, dm_nxt, out_en_nxt, busy_nxt, underrun_nxt;
  logic       data_k;

  assign in_ready = (state == DATA);

  // Symbol for the incoming data bit: 1 holds, 0 toggles.
  assign data_k = in_bit ? ref_k : ~ref_k;

  always_comb begin
    state_nxt     = state;
    sync_cnt_nxt  = sync_cnt;
    ones_cnt_nxt  = ones_cnt;
    ref_k_nxt     = ref_k;
    last_flag_nxt = last_flag;
    dp_nxt        = dp;
    dm_nxt        = dm;
    out_en_nxt    = out_en;
    busy_nxt      = busy;
    underrun_nxt  = 1'b0;

    case (state)
      IDLE: begin
        dp_nxt       = 1'b1;
        dm_nxt       = 1'b0;
        out_en_nxt   = 1'b0;
        busy_nxt     = 1'b0;
        ref_k_nxt    = 1'b0;
        ones_cnt_nxt = 3'd0;
        if (in_valid) begin
          // First SYNC bit is a 0: toggle from J to K.
          ref_k_nxt    = 1'b1;
          dp_nxt       = 1'b0;
          dm_nxt       = 1'b1;
          out_en_nxt   = 1'b1;
          busy_nxt     = 1'b1;
          sync_cnt_nxt = 3'd1;
          state_nxt    = SYNC;
        end
      end

      SYNC: begin
        if (sync_cnt == 3'd7) begin
          // Final SYNC bit is a 1: hold, and it counts toward stuffing.
          dp_nxt       = ~ref_k;
          dm_nxt       = ref_k;
          ones_cnt_nxt = 3'd1;
          state_nxt    = DATA;
        end else begin
          ref_k_nxt    = ~ref_k;
          dp_nxt       = ref_k;
          dm_nxt       = ~ref_k;
          sync_cnt_nxt = sync_cnt + 3'd1;
        end
      end

      DATA: begin
        if (in_valid) begin
          ref_k_nxt = data_k;
          dp_nxt    = ~data_k;
          dm_nxt    = data_k;
          if (in_bit) begin
            ones_cnt_nxt = ones_cnt + 3'd1;
          end else begin
            ones_cnt_nxt = 3'd0;
          end
          if (in_bit && ones_cnt == 3'd5) begin
            last_flag_nxt = in_last;
            state_nxt     = STUFF;
          end else if (in_last) begin
            state_nxt = EOP1;
          end
        end else begin
          // Starved mid-packet: abort straight into the second half of EOP
          // so the line still sees two SE0 cycles.
          dp_nxt       = 1'b0;
          dm_nxt       = 1'b0;
          underrun_nxt = 1'b1;
          state_nxt    = EOP2;
        end
      end

      STUFF: begin
        ref_k_nxt    = ~ref_k;
        dp_nxt       = ref_k;
        dm_nxt       = ~ref_k;
        ones_cnt_nxt = 3'd0;
        state_nxt    = last_flag ? EOP1 : DATA;
      end

      EOP1: begin
        dp_nxt    = 1'b0;
        dm_nxt    = 1'b0;
        state_nxt = EOP2;
      end

      EOP2: begin
        dp_nxt    = 1'b0;
        dm_nxt    = 1'b0;
        state_nxt = EOPJ;
      end

      EOPJ: begin
        dp_nxt    = 1'b1;
        dm_nxt    = 1'b0;
        ref_k_nxt = 1'b0;
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state     <= IDLE;
      sync_cnt  <= 3'd0;
      ones_cnt  <= 3'd0;
      ref_k     <= 1'b0;
      last_flag <= 1'b0;
      dp        <= 1'b1;
      dm        <= 1'b0;
      out_en    <= 1'b0;
      busy      <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      state     <= state_nxt;
      sync_cnt  <= sync_cnt_nxt;
      ones_cnt  <= ones_cnt_nxt;
      ref_k     <= ref_k_nxt;
      last_flag <= last_flag_nxt;
      dp        <= dp_nxt;
      dm        <= dm_nxt;
      out_en    <= out_en_nxt;
      busy      <= busy_nxt;
      underrun  <= underrun_nxt;
    end
  end

endmodule

// File: tb/tb_usb_nrzi_tx.sv
// Directed bench for usb_nrzi_tx. Expected line sequences are written out
// by hand as strings of J, K and 0 (SE0), one character per bus cycle.
module tb_usb_nrzi_tx;

  logic clk;
  logic rst_L;
  logic in_valid;
  logic in_bit;
  logic in_last;
  logic in_ready;
  logic dp;
  logic dm;
  logic out_en;
  logic busy;
  logic underrun;

  int tests = 0;
  int fails = 0;

  usb_nrzi_tx dut (
    .clk      (clk),
    .rst_L    (rst_L),
    .in_valid (in_valid),
    .in_bit   (in_bit),
    .in_last  (in_last),
    .in_ready (in_ready),
    .dp       (dp),
    .dm       (dm),
    .out_en   (out_en),
    .busy     (busy),
    .underrun (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] sym(input byte c);
    case (c)
      "J":     return 2'b10;
      "K":     return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  // Starts at a negedge with the DUT idle. Sends n bits of 'bits' LSB-first,
  // but withholds in_valid once 'stop' bits have been consumed.
  task automatic run_pkt(input string name, input logic [7:0] bits, input int n,
                         input int stop, input string exp_line,
                         input int exp_ready, input int exp_under);
    int idx = 0;
    int rdy_cnt = 0;
    int und_cnt = 0;
    in_valid = 1'b1;
    in_bit   = bits[0];
    in_last  = (n == 1);
    for (int c = 0; c < exp_line.len(); c++) begin
      @(negedge clk);
      chk($sformatf("%s line c%0d", name, c), {6'd0, dp, dm}, {6'd0, sym(exp_line[c])});
      chk($sformatf("%s out_en c%0d", name, c), {7'd0, out_en}, 8'd1);
      chk($sformatf("%s busy c%0d", name, c), {7'd0, busy}, 8'd1);
      if (in_ready) rdy_cnt++;
      if (underrun) und_cnt++;
      in_valid = (idx < n) && (idx < stop);
      in_bit   = (idx < n) ? bits[idx] : 1'b0;
      in_last  = (idx == n - 1);
      if (in_ready && in_valid) idx++;
    end
    @(negedge clk);
    chk({name, " idle line"}, {6'd0, dp, dm}, 8'h02);
    chk({name, " idle out_en"}, {7'd0, out_en}, 8'd0);
    chk({name, " idle busy"}, {7'd0, busy}, 8'd0);
    chk({name, " ready cycles"}, rdy_cnt[7:0], exp_ready[7:0]);
    chk({name, " underrun pulses"}, und_cnt[7:0], exp_under[7:0]);
    in_valid = 1'b0;
  endtask

  initial begin
    rst_L    = 1'b0;
    in_valid = 1'b1;
    in_bit   = 1'b0;
    in_last  = 1'b0;

    // Reset held with in_valid high.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset line", {6'd0, dp, dm}, 8'h02);
      chk("reset out_en", {7'd0, out_en}, 8'd0);
      chk("reset busy", {7'd0, busy}, 8'd0);
      chk("reset in_ready", {7'd0, in_ready}, 8'd0);
      chk("reset underrun", {7'd0, underrun}, 8'd0);
    end
    in_valid = 1'b0;
    rst_L    = 1'b1;
    @(negedge clk);

    run_pkt("byte00", 8'h00, 8, 8, "KJKJKJKKJKJKJKJK00J", 8, 0);
    run_pkt("byteFF", 8'hFF, 8, 8, "KJKJKJKKKKKKKJJJJ00J", 8, 0);
    run_pkt("trail_stuff", 8'h7E, 7, 7, "KJKJKJKKJJJJJJJK00J", 7, 0);
    run_pkt("byteA5", 8'hA5, 8, 8, "KJKJKJKKKJJKJJKK00J", 8, 0);
    run_pkt("underrun", 8'h02, 8, 3, "KJKJKJKKJJK00J", 4, 1);

    // Reset asserted mid-packet.
    in_valid = 1'b1;
    in_bit   = 1'b0;
    in_last  = 1'b0;
    for (int i = 0; i < 12; i++) @(negedge clk);
    chk("pre-reset in DATA", {7'd0, in_ready}, 8'd1);
    chk("pre-reset out_en", {7'd0, out_en}, 8'd1);
    #2 rst_L = 1'b0;
    #1;
    chk("midrst line", {6'd0, dp, dm}, 8'h02);
    chk("midrst out_en", {7'd0, out_en}, 8'd0);
    chk("midrst busy", {7'd0, busy}, 8'd0);
    chk("midrst in_ready", {7'd0, in_ready}, 8'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_L = 1'b1;
    @(negedge clk);
    run_pkt("after_rst", 8'h00, 8, 8, "KJKJKJKKJKJKJKJK00J", 8, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
